// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums len signed psums into a full-precision dot product,
// then presents it with a shifted, saturated 8-bit view. Optional ReLU via PSUM_RELU_EN.
module psum_accum #(
    parameter int unsigned bw_psum = 20,
    parameter int unsigned cnt_w   = 6,
    parameter int unsigned bw_acc  = 26,
    parameter int unsigned bw_out  = 8,
    parameter int unsigned sh_w    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [cnt_w-1:0]          len,
    input  logic [sh_w-1:0]           shift,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [bw_psum-1:0] psum_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [bw_acc-1:0]  acc_out,
    output logic signed [bw_out-1:0]  q_out,
    output logic                      busy,
    output logic                      err
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [bw_acc-1:0] Q_MAX = bw_acc'((64'd1 << (bw_out - 1)) - 64'd1);
    localparam logic signed [bw_acc-1:0] Q_MIN = ~Q_MAX;

    state_t                     r_state;
    logic signed [bw_acc-1:0]   r_acc;
    logic [cnt_w-1:0]           r_count;
    logic [cnt_w-1:0]           r_len;
    logic [sh_w-1:0]            r_shift;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic                       r_busy;
    logic                       r_err;
    logic signed [bw_out-1:0]   r_q;

    logic signed [bw_acc-1:0]   w_psum_ext;
    logic signed [bw_acc-1:0]   w_acc_next;
    logic signed [bw_acc-1:0]   w_shifted;
    logic signed [bw_out-1:0]   w_q;
    logic                       w_beat;
    logic                       w_last;

    assign w_psum_ext = {{(bw_acc - bw_psum){psum_in[bw_psum-1]}}, psum_in};
    assign w_acc_next = r_acc + w_psum_ext;
    assign w_beat     = in_valid && r_in_ready;
    assign w_last     = (r_count == r_len - cnt_w'(1));

    // Quantize the sum that will be final on the beat entering DONE
    always_comb begin
        w_shifted = w_acc_next >>> r_shift;
        if (32'(r_shift) >= bw_acc) begin
            w_shifted = {bw_acc{w_acc_next[bw_acc-1]}};
        end
        w_q = w_shifted[bw_out-1:0];
`ifdef PSUM_RELU_EN
        if (w_shifted < 0) begin
            w_q = '0;
        end else if (w_shifted > Q_MAX) begin
            w_q = Q_MAX[bw_out-1:0];
        end
`else
        if (w_shifted > Q_MAX) begin
            w_q = Q_MAX[bw_out-1:0];
        end else if (w_shifted < Q_MIN) begin
            w_q = Q_MIN[bw_out-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_q         <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_len      <= len;
                            r_shift    <= shift;
                            r_acc      <= '0;
                            r_count    <= '0;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= ACCUM;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + cnt_w'(1);
                        if (w_last) begin
                            r_q         <= w_q;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Start pulses are ignored here, even alongside the handshake
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign q_out     = r_q;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: directed cases plus randomized runs checked against an
// arithmetic reference (sum of beats, shift, clamp).
module tb_psum_accum;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [5:0]          len;
    logic [4:0]          shift;
    logic                in_valid;
    logic                in_ready;
    logic signed [19:0]  psum_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [25:0]  acc_out;
    logic signed [7:0]   q_out;
    logic                busy;
    logic                err;

    int n_pass  = 0;
    int n_total = 0;
    int beats[$];

    always #5 clk = ~clk;

    psum_accum dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .shift     (shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .psum_in   (psum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .q_out     (q_out),
        .busy      (busy),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint model_q(input longint sum, input int sh);
        longint s;
        s = sum >>> sh;
`ifdef PSUM_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    // One full run over the queued beats with random input gaps and bp cycles of backpressure
    task automatic run(input int ln, input int sh, input int max_gap, input int bp);
        longint sum = 0;
        longint eq;
        foreach (beats[i]) sum += beats[i];
        eq = model_q(sum, sh);
        start = 1'b1; len = 6'(ln); shift = 5'(sh);
        tick();
        start = 1'b0;
        chk("in_ready_after_start", in_ready, 1);
        chk("busy_after_start", busy, 1);
        chk("no_err_on_start", err, 0);
        foreach (beats[i]) begin
            int g = $urandom_range(0, max_gap);
            repeat (g) begin
                start = 1'b1; len = 6'(0);
                tick();
                start = 1'b0;
                chk("stall_in_ready", in_ready, 1);
                chk("stall_no_err", err, 0);
            end
            in_valid = 1'b1; psum_in = 20'(beats[i]);
            tick();
            in_valid = 1'b0;
            if (i < beats.size() - 1) chk("early_out_valid", out_valid, 0);
        end
        chk("out_valid_latency", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        chk("acc_out", acc_out, sum);
        chk("q_out", q_out, eq);
        repeat (bp) begin
            start = 1'b1; len = 6'(3);
            tick();
            start = 1'b0;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_acc_stable", acc_out, sum);
            chk("bp_q_stable", q_out, eq);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_no_err", err, 0);
        end
        out_ready = 1'b1; start = 1'b1; len = 6'(2);
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_in_ready", in_ready, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; shift = '0;
        in_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_q_out", q_out, 0);

        // Reset in the middle of a run discards it
        start = 1'b1; len = 6'(4); shift = 5'(0);
        tick();
        start = 1'b0;
        in_valid = 1'b1; psum_in = 20'(9); tick();
        psum_in = 20'(13); tick();
        in_valid = 1'b0;
        chk("mid_acc_partial", acc_out, 22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_acc_out", acc_out, 0);
        chk("midrst_busy", busy, 0);
        beats = '{5, 6};
        run(2, 0, 0, 0);

        beats = '{100, -30, 7};
        run(3, 0, 3, 1);
        beats = '{1000, 1000};
        run(2, 2, 1, 0);
        beats = '{-1000, -1000};
        run(2, 2, 1, 0);
        beats = '{};
        repeat (63) beats.push_back(-524288);
        run(63, 0, 0, 5);
        chk("min_sum_exact", acc_out, -33030144);
        beats = '{-5};
        run(1, 31, 0, 0);
        beats = '{77};
        run(1, 31, 0, 0);

        // Illegal start
        start = 1'b1; len = 6'(0);
        tick();
        start = 1'b0;
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        chk("len0_in_ready", in_ready, 0);
        tick();
        chk("len0_err_pulse", err, 0);

        for (int r = 0; r < 16; r++) begin
            int ln;
            int sh;
            logic signed [19:0] p;
            ln = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 63) : $urandom_range(1, 6);
            sh = $urandom_range(0, 31);
            beats = '{};
            for (int k = 0; k < ln; k++) begin
                p = 20'($urandom);
                if ($urandom_range(0, 1) == 0) p = 20'(int'($urandom_range(0, 300)) - 150);
                beats.push_back(int'(p));
            end
            run(ln, sh, 2, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Downstream stage of the 16-input MAC.
- Accumulates a run of signed 20-bit partial sums (one per 16-element chunk) into a full dot product of length len*16.
- Presents the result with a valid/ready handshake, both at full precision and as an arithmetic-shifted, saturated 8-bit activation.
- Sits between the MAC array and the output/activation buffer.

Parameters:
- bw_psum, 20, width of incoming signed partial sum.
- cnt_w, 6, width of chunk counter; max run length 2^cnt_w - 1.
- bw_acc, 26, accumulator width; must equal bw_psum+cnt_w so overflow is impossible.
- bw_out, 8, width of quantized signed output.
- sh_w, 5, width of shift amount.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- start, input, 1, pulse: begin a new run.
- len, input, cnt_w, chunks in run; sampled when start is accepted.
- shift, input, sh_w, right-shift for quantization; sampled when start is accepted.
- in_valid, input, 1, psum_in valid.
- in_ready, output, 1, block accepts psum this cycle.
- psum_in, input, bw_psum, signed partial sum from the MAC.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer takes result.
- acc_out, output, bw_acc, signed full-precision sum.
- q_out, output, bw_out, signed quantized result.
- busy, output, 1, high when not IDLE.
- err, output, 1, one-cycle pulse on an illegal start.

Behaviour:
- Reset (synchronous, active-high, clock clk): state=IDLE; acc, count, len_q, shift_q = 0; in_ready=0, out_valid=0, busy=0, err=0; acc_out=0, q_out=0.
- Reset overrides any in-flight run. A partial accumulation is discarded and produces no output.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start with len!=0: latch len_q, shift_q; clear acc and count; go to ACCUM next cycle.
  - start with len==0: stay in IDLE; err=1 for one cycle.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc <= acc + sign_ext(psum_in); count++.
  - If the accepted beat has count==len_q-1: go to DONE.
  - in_valid low: hold, no change.
- DONE:
  - in_ready=0; out_valid=1.
  - acc_out, q_out stable until out_ready is sampled high.
  - On out_valid&&out_ready: go to IDLE; out_valid=0 next cycle.
- Latency:
  - Start accepted at cycle t → in_ready=1 at t+1.
  - Last psum accepted at t → out_valid=1 and final acc_out at t+1.
  - len=1 → minimum run of 3 cycles from start to out_valid.
- start while busy: ignored, no err, run unaffected.
- start in the same cycle as a DONE handshake: ignored. A new start requires IDLE.
- acc_out = acc (registered).
- q_out is registered and computed on entry to DONE from the final sum:
  - s = final sum >>> shift_q (arithmetic);
  - clamp s to [-2^(bw_out-1), 2^(bw_out-1)-1];
  - shift_q >= bw_acc → s = sign.
- Sign extension: psum_in[bw_psum-1] is replicated to bw_acc.
- Upstream stalls (in_valid low mid-run) are allowed indefinitely. Downstream backpressure (out_ready low) holds DONE indefinitely.
- busy=1 in ACCUM and DONE.

Optional Feature:
- Macro PSUM_RELU_EN.
- Defined: q_out is forced to 0 when the shifted value is negative (ReLU applied before saturation); acc_out is unaffected.
- Undefined: q_out is the signed saturated value, as above.

Test Plan:
- Reset mid-ACCUM (len=4, 2 beats in) → next cycle IDLE, in_ready=0, out_valid=0, acc_out=0. A new start with len=2 and psums 5, 6 → acc_out=11.
- len=3, shift=0, psums 100, -30, 7 with in_valid gaps → out_valid one cycle after the third beat; acc_out=77, q_out=77.
- len=2, shift=2, psums 1000, 1000 → acc_out=2000, q_out=127 (saturated). Psums -1000, -1000 → q_out=-128 (or 0 with PSUM_RELU_EN).
- len=63, every psum=-524288 (min 20-bit) → acc_out=-33030144 with no overflow; q_out=-128 (shift=0).
- out_ready held low 5 cycles in DONE → outputs stable, in_ready=0, a start pulse is ignored. out_ready=1 → IDLE next cycle.
- start with len=0 → err pulses for one cycle, state remains IDLE, busy=0.
